// File: rtl/ram_access_arbiter_pkg.sv
// Shared definitions for the RAM access arbiter: default widths, FSM encoding
// and the CRC-4 (x^4+x+1) serial step used when MEM_CRC_EN is defined.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 3;
  localparam int MEM_DATA_W = 4;

  localparam logic [3:0] CRC4_POLY = 4'b0011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // One bit of an MSB-first CRC-4 shift.
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
    logic fb;
    fb = crc[3] ^ din;
    return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
  endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Request/response bundle between the two host requesters and the arbiter.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);

  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic                rsp_write;
  logic [DATA_W-1:0]   rsp_data;
  logic [3:0]          rsp_crc;
  logic                rsp_timeout;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_write, rsp_data, rsp_crc, rsp_timeout
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_write, rsp_data, rsp_crc, rsp_timeout
  );

endinterface

// File: rtl/ram_access_arbiter_arb.sv
// Two-input round-robin arbiter: the pointer names the favoured requester and
// moves to the losing side whenever a grant is accepted.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one register-file RAM between two requesters: IDLE -> ACCESS -> RESP.
// Define MEM_CRC_EN to register a CRC-4 of {addr, data} with each response.
module ram_access_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int RSP_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  ram_access_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [DATA_W-1:0]  ram_data_in,
  output logic               ram_write_enable,
  output logic               ram_read_enable,
  input  logic [DATA_W-1:0]  ram_data_out
);

  localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [1:0]          gnt;
  logic                accept;
  logic                id_q, write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rsp_id_q, rsp_write_q, rsp_timeout_q;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo_fire;

  assign accept = |(bus.req_valid & gnt);

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (state_q == IDLE),
    .req_i   (bus.req_valid),
    .accept_i(accept),
    .gnt_o   (gnt)
  );

  assign tmo_fire = (RSP_TIMEOUT != 0) && (state_q == RESP) && !bus.rsp_ready
                    && (cnt_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.rsp_ready || tmo_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Enables are masked by reset so a reset landing in ACCESS never commits the write.
  always_comb begin
    bus.req_ready    = gnt;
    bus.rsp_valid    = (state_q == RESP);
    ram_address      = '0;
    ram_data_in      = '0;
    ram_write_enable = 1'b0;
    ram_read_enable  = 1'b0;
    if (state_q == ACCESS && !reset) begin
      ram_address      = addr_q;
      ram_data_in      = wdata_q;
      ram_write_enable = write_q;
      ram_read_enable  = !write_q;
    end
  end

  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  assign rsp_data_d = write_q ? wdata_q : ram_data_out;

  always_comb begin
    cnt_d = '0;
    if (state_q == RESP && !bus.rsp_ready && !tmo_fire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q          <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_id_q      <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      if (accept) begin
        id_q    <= gnt[1];
        write_q <= gnt[1] ? bus.req_write[1] : bus.req_write[0];
        addr_q  <= gnt[1] ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        wdata_q <= gnt[1] ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      end
      if (state_q == ACCESS) begin
        rsp_id_q    <= id_q;
        rsp_write_q <= write_q;
        rsp_data_q  <= rsp_data_d;
      end
      rsp_timeout_q <= tmo_fire;
      cnt_q         <= cnt_d;
    end
  end

`ifdef MEM_CRC_EN
  logic [3:0] crc_d, rsp_crc_q;

  always_comb begin
    crc_d = 4'b0000;
    for (int i = ADDR_W - 1; i >= 0; i--) crc_d = crc4_step(crc_d, addr_q[i]);
    for (int i = DATA_W - 1; i >= 0; i--) crc_d = crc4_step(crc_d, rsp_data_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset)                  rsp_crc_q <= 4'b0000;
    else if (state_q == ACCESS) rsp_crc_q <= crc_d;
  end

  assign bus.rsp_crc = rsp_crc_q;
`else
  assign bus.rsp_crc = 4'b0000;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed, scoreboard-checked bench for ram_access_arbiter with a behavioural
// 8x4 RAM; expected CRC follows MEM_CRC_EN.
module tb_ram_access_arbiter;

  typedef struct packed {
    logic       id;
    logic       wr;
    logic [3:0] data;
    logic [3:0] crc;
  } rsp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ram_address;
  logic [3:0] ram_data_in;
  logic       ram_write_enable;
  logic       ram_read_enable;
  logic [3:0] ram_data_out;

  logic [3:0] ramMem[8];
  logic [3:0] modelMem[8];
  logic       modelPtr;
  rsp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;

  ram_access_arbiter_if #(.ADDR_W(3), .DATA_W(4)) bus ();

  ram_access_arbiter #(.ADDR_W(3), .DATA_W(4), .RSP_TIMEOUT(15)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .ram_address     (ram_address),
    .ram_data_in     (ram_data_in),
    .ram_write_enable(ram_write_enable),
    .ram_read_enable (ram_read_enable),
    .ram_data_out    (ram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural register-file RAM: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_write_enable) ramMem[ram_address] <= ram_data_in;
  end
  assign ram_data_out = ramMem[ram_address];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] crcModel(input logic [2:0] a, input logic [3:0] d);
    logic [6:0] s;
    logic [3:0] c;
    s = {a, d};
    c = 4'h0;
    for (int i = 6; i >= 0; i--) begin
      if (c[3] ^ s[i]) c = {c[2:0], 1'b0} ^ 4'h3;
      else             c = {c[2:0], 1'b0};
    end
`ifdef MEM_CRC_EN
    return c;
`else
    return 4'h0;
`endif
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] wr,
                               input logic [2:0] a0, input logic [2:0] a1,
                               input logic [3:0] d0, input logic [3:0] d1);
    bus.req_valid = valid;
    bus.req_write = wr;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
  endtask

  // Model arbitration and push the expected response for the winner.
  task automatic acceptStep(input string tag, output logic winner);
    rsp_t       e;
    logic [2:0] a;
    logic [3:0] d;
    logic       w;
    if (bus.req_valid == 2'b10)      winner = 1'b1;
    else if (bus.req_valid == 2'b01) winner = 1'b0;
    else                             winner = modelPtr;
    checkOutput({tag, "_grant"}, 8'(bus.req_ready), winner ? 8'h02 : 8'h01);
    a = winner ? bus.req_addr[5:3]  : bus.req_addr[2:0];
    d = winner ? bus.req_wdata[7:4] : bus.req_wdata[3:0];
    w = bus.req_write[winner];
    e.id   = winner;
    e.wr   = w;
    e.data = w ? d : modelMem[a];
    e.crc  = crcModel(a, e.data);
    if (w) modelMem[a] = d;
    sbq.push_back(e);
    modelPtr = ~winner;
  endtask

  task automatic checkResponse(input string tag);
    rsp_t e;
    checkOutput({tag, "_sbq"}, 8'(sbq.size() > 0), 8'h01);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput({tag, "_id"},   8'(bus.rsp_id),    8'(e.id));
      checkOutput({tag, "_wr"},   8'(bus.rsp_write), 8'(e.wr));
      checkOutput({tag, "_data"}, 8'(bus.rsp_data),  8'(e.data));
      checkOutput({tag, "_crc"},  8'(bus.rsp_crc),   8'(e.crc));
    end
  endtask

  // One full transaction with rsp_ready high; returns the modelled winner.
  task automatic doTxn(input string tag, input logic [1:0] valid, input logic [1:0] wr,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [3:0] d0, input logic [3:0] d1, output logic winner);
    int         n;
    logic [2:0] a;
    logic [3:0] d;
    logic       w;
    applyStimulus(valid, wr, a0, a1, d0, d1);
    #1;
    n = 0;
    while ((bus.req_valid & bus.req_ready) == 2'b00 && n < 4) begin
      cyc;
      n++;
    end
    acceptStep(tag, winner);
    a = winner ? a1 : a0;
    d = winner ? d1 : d0;
    w = wr[winner];
    cyc;
    checkOutput({tag, "_we"},   8'(ram_write_enable), 8'(w));
    checkOutput({tag, "_re"},   8'(ram_read_enable),  8'(!w));
    checkOutput({tag, "_addr"}, 8'(ram_address),      8'(a));
    if (w) checkOutput({tag, "_din"}, 8'(ram_data_in), 8'(d));
    bus.req_valid[winner] = 1'b0;
    cyc;
    checkOutput({tag, "_en_off"}, 8'({ram_write_enable, ram_read_enable}), 8'h00);
    checkOutput({tag, "_valid"},  8'(bus.rsp_valid), 8'h01);
    checkResponse(tag);
    cyc;
    checkOutput({tag, "_done"}, 8'(bus.rsp_valid), 8'h00);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdy"},  8'(bus.req_ready),   8'h00);
    checkOutput({tag, "_rv"},   8'(bus.rsp_valid),   8'h00);
    checkOutput({tag, "_rid"},  8'(bus.rsp_id),      8'h00);
    checkOutput({tag, "_rwr"},  8'(bus.rsp_write),   8'h00);
    checkOutput({tag, "_rd"},   8'(bus.rsp_data),    8'h00);
    checkOutput({tag, "_crc"},  8'(bus.rsp_crc),     8'h00);
    checkOutput({tag, "_tmo"},  8'(bus.rsp_timeout), 8'h00);
    checkOutput({tag, "_ram"},  8'({ram_write_enable, ram_read_enable, ram_address, ram_data_in}), 8'h00);
  endtask

  initial begin
    logic       win;
    int         cnt;
    logic [1:0] k0, k1;
    logic [2:0] seqA0[2], seqA1[2];
    logic [3:0] seqD0[2];

    for (int i = 0; i < 8; i++) begin
      ramMem[i]   = 4'h0;
      modelMem[i] = 4'h0;
    end
    modelPtr      = 1'b0;
    reset         = 1'b1;
    bus.rsp_ready = 1'b1;
    applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
    repeat (2) cyc;
    checkAllZero("reset");
    reset = 1'b0;
    cyc;

    // Write by requester 0, then read back through requester 1.
    doTxn("t1_wr", 2'b01, 2'b01, 3'd3, 3'd0, 4'h9, 4'h0, win);
    doTxn("t2_rd", 2'b10, 2'b00, 3'd0, 3'd3, 4'h0, 4'h0, win);

    // Both requesters held valid: writes from 0 interleave with reads from 1.
    seqA0[0] = 3'd6; seqA0[1] = 3'd7;
    seqD0[0] = 4'h5; seqD0[1] = 4'h6;
    seqA1[0] = 3'd6; seqA1[1] = 3'd7;
    k0 = 2'd0;
    k1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      doTxn("t3_rr", {k1 < 2'd2, k0 < 2'd2}, 2'b01,
            seqA0[k0[0]], seqA1[k1[0]], seqD0[k0[0]], 4'h0, win);
      checkOutput("t3_order", 8'(win), 8'(i % 2));
      if (win) k1++;
      else     k0++;
    end

    // Response never consumed: held 15 cycles, then dropped with a timeout pulse.
    bus.rsp_ready = 1'b0;
    applyStimulus(2'b01, 2'b00, 3'd6, 3'd0, 4'h0, 4'h0);
    #1;
    acceptStep("t4_tmo", win);
    cyc;
    applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
    cyc;
    checkResponse("t4_tmo");
    cnt = 0;
    while (bus.rsp_valid && cnt < 40) begin
      checkOutput("t4_nopulse", 8'(bus.rsp_timeout), 8'h00);
      cnt++;
      cyc;
    end
    checkOutput("t4_len",   8'(cnt),             8'd15);
    checkOutput("t4_pulse", 8'(bus.rsp_timeout), 8'h01);
    cyc;
    checkOutput("t4_pulse_end", 8'(bus.rsp_timeout), 8'h00);
    bus.rsp_ready = 1'b1;
    doTxn("t4_next", 2'b10, 2'b00, 3'd0, 3'd3, 4'h0, 4'h0, win);

    // Reset during the ACCESS cycle of a write: the write must not land.
    applyStimulus(2'b01, 2'b01, 3'd5, 3'd0, 4'hF, 4'h0);
    #1;
    checkOutput("t5_grant", 8'(bus.req_ready), 8'h01);
    cyc;
    checkOutput("t5_we", 8'(ram_write_enable), 8'h01);
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 3'd0, 3'd0, 4'h0, 4'h0);
    cyc;
    checkAllZero("t5_rst");
    reset    = 1'b0;
    modelPtr = 1'b0;
    doTxn("t5_rd5", 2'b11, 2'b00, 3'd5, 3'd3, 4'h0, 4'h0, win);
    doTxn("t5_rd3", 2'b10, 2'b00, 3'd0, 3'd3, 4'h0, 4'h0, win);

    // CRC vector and read-back of the same word.
    doTxn("t6_crc", 2'b01, 2'b01, 3'd5, 3'd0, 4'hA, 4'h0, win);
    doTxn("t6_rd",  2'b01, 2'b00, 3'd5, 3'd0, 4'h0, 4'h0, win);
    checkOutput("t6_vec", 8'(crcModel(3'b101, 4'hA)),
`ifdef MEM_CRC_EN
                8'h0F);
`else
                8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Two-requester controller that shares the 8x4 register-file RAM.
- Round-robin arbitration between requesters 0 and 1.
- Sequences each granted request as a single RAM access cycle: drives address, data_in, write_enable and read_enable.
- Captures read data and returns a response through a valid/ready handshake.
- Sits between the host-side request logic and the RAM instance in the mem_access top level.

Parameters:
- ADDR_W, 3, RAM address width (8 words)
- DATA_W, 4, RAM word width
- RSP_TIMEOUT, 15, cycles RESP waits for rsp_ready before dropping the response; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid
- req_write  in  2  per-requester op: 1 = write, 0 = read
- req_addr  in  2*ADDR_W  per-requester address; requester n uses slice n
- req_wdata  in  2*DATA_W  per-requester write data
- req_ready  out  2  one-hot grant; request accepted when valid & ready
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_write  out  1  1 = write ack, 0 = read data
- rsp_data  out  DATA_W  read data, or echoed write data for a write ack
- rsp_crc  out  4  CRC-4 of {addr, data}; 0 when feature is off
- rsp_timeout  out  1  one-cycle pulse when a response is dropped
- ram_address  out  ADDR_W  to RAM address
- ram_data_in  out  DATA_W  to RAM data_in
- ram_write_enable  out  1  to RAM write_enable
- ram_read_enable  out  1  to RAM read_enable
- ram_data_out  in  DATA_W  from RAM data_out (combinational read)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state=IDLE, priority pointer=0 (requester 0 favoured), all outputs 0.
- Reset mid-operation aborts the access. No RAM write occurs on the reset edge, because the write cycle is ACCESS and reset forces IDLE.
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - req_ready is combinational. It is nonzero only in IDLE, one-hot to the arbitration winner.
  - Single valid wins outright. Both valid: the pointer side wins.
  - On accept: latch id/write/addr/wdata, go to ACCESS, set pointer to the loser (other id).
- ACCESS (exactly 1 cycle)
  - Drive ram_address and ram_data_in from the latched request.
  - ram_write_enable = latched write; ram_read_enable = !latched write.
  - Enables are 0 in every other state.
  - At the end of the cycle: capture rsp_data (ram_data_out for reads, latched wdata for writes). Go to RESP.
- RESP
  - rsp_valid = 1; rsp_id, rsp_write, rsp_data, rsp_crc are held stable.
  - rsp_valid & rsp_ready → IDLE next cycle.
  - Timeout counter counts cycles in RESP without rsp_ready. On reaching RSP_TIMEOUT: drop the response, pulse rsp_timeout, go to IDLE.
  - A write already performed is not undone.
- Latency: accept edge → rsp_valid 2 cycles later. Minimum 3 cycles per transaction; no overlap.
- Read-after-write to the same address always returns the new data, because the RAM is updated at the end of ACCESS.
- Request inputs are ignored outside IDLE.
- Requesters must hold valid and payload until accepted.
- Deassertion of valid before grant is legal.

Optional Feature:
Macro MEM_CRC_EN.
- Defined: CRC-4 is computed in ACCESS and registered with rsp_data.
  - Polynomial x^4+x+1 (4'b0011), init 0.
  - Input is 7 bits, address MSB first then data MSB first.
- Undefined: rsp_crc is tied to 0 and no CRC logic is generated.

Decomposition:
- Package mem_ctrl_pkg holds:
  - ADDR_W and DATA_W defaults
  - FSM state encoding (IDLE=0, ACCESS=1, RESP=2)
  - CRC4_POLY = 4'b0011
  - a CRC-4 step function
- One sub-module, rr_arbiter_2: 2-input round-robin with pointer register, update-on-accept input, and one-hot grant output.

Test Plan:
1. After reset, only requester 0 writes addr 3, data 4'h9 → req_ready=2'b01 that cycle; ram_write_enable high exactly 1 cycle with ram_address=3; rsp_valid 2 cycles later with rsp_write=1, rsp_data=4'h9, rsp_id=0.
2. Read addr 3 following case 1 → ram_read_enable 1 cycle; rsp_data=4'h9, rsp_write=0.
3. Both requesters valid continuously, 4 transactions → grant order 0,1,0,1; no response lost; rsp_id alternates.
4. rsp_ready held low after a read with RSP_TIMEOUT=15 → rsp_valid high 15 cycles, then rsp_timeout pulses once; FSM in IDLE; next request is accepted.
5. Reset asserted in ACCESS of a write to addr 5, data 4'hF → addr 5 remains 0 on a later read; all outputs 0 the cycle after reset.
6. MEM_CRC_EN defined, write addr 3'b101, data 4'hA → rsp_crc=4'hF; without the macro, rsp_crc=0.
